// File: rtl/pulse_scheduler.sv
// rtl/pulse_scheduler.sv - sequential multi-channel delayed pulse generator
module pulse_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic              cfg_idle,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_CH-1:0] pulse_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        active_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PULSE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  state_t             state, state_n;
  logic [2:0]         ch, ch_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [CNT_W-1:0]   delay_r [NUM_CH];
  logic [CNT_W-1:0]   width_r [NUM_CH];
  logic [NUM_CH-1:0]  idle_r;

  logic [CNT_W-1:0]   cur_width;
  logic [CNT_W-1:0]   nxt_delay;
  logic [NUM_CH-1:0]  pulse_n;

  // Channel configuration registers; writes only land while no sequence runs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        delay_r[i] <= '0;
        width_r[i] <= '0;
      end
      idle_r <= '0;
    end else if (cfg_we && !busy) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(cfg_ch) == i) begin
          delay_r[i] <= cfg_delay;
          width_r[i] <= cfg_width;
          idle_r[i]  <= cfg_idle;
        end
      end
    end
  end

  // Select the width of the current channel and the delay of the following one
  always_comb begin
    cur_width = '0;
    nxt_delay = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 3'(i)) cur_width = width_r[i];
      if (ch + 3'd1 == 3'(i)) nxt_delay = delay_r[i];
    end
  end

  // Sequencer state, channel index and shared delay/width counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      ch    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; the counter only decrements when nonzero so it never wraps
  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_WAIT;
          ch_n    = '0;
          cnt_n   = delay_r[0];
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          if (cur_width == '0) begin
            state_n = S_NEXT;
          end else begin
            state_n = S_PULSE;
            cnt_n   = cur_width - 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt == '0) state_n = S_NEXT;
        else           cnt_n   = cnt - 1'b1;
      end
      S_NEXT: begin
        if (ch == LAST_CH) begin
          state_n = S_DONE;
        end else begin
          state_n = S_WAIT;
          ch_n    = ch + 3'd1;
          cnt_n   = nxt_delay;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        ch_n    = '0;
      end
      default: begin
        state_n = S_IDLE;
        ch_n    = '0;
        cnt_n   = '0;
      end
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      ch_n    = '0;
      cnt_n   = '0;
    end
  end

  // Channel output levels: idle everywhere except the channel in its active window
  always_comb begin
    pulse_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_n[i] = idle_r[i] ^ (state == S_PULSE && ch == 3'(i) && !abort);
    end
  end

  // Registered channel outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) pulse_out <= '0;
    else        pulse_out <= pulse_n;
  end

  assign busy      = (state == S_WAIT) || (state == S_PULSE) || (state == S_NEXT);
  assign done      = (state == S_DONE);
  assign active_ch = (state == S_WAIT || state == S_PULSE) ? ch : 3'd0;

endmodule
